// File: rtl/regwb.sv
// rtl/regwb.sv - register writeback stage merging ALU and buffered memory results
// The register file's single write port is shared; a full memory FIFO takes priority over the ALU.
module regwb #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [3:0]               alu_waddr,
  input  logic [23:0]              alu_wdata,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [3:0]               mem_waddr,
  input  logic [23:0]              mem_wdata,
  output logic                     rf_we,
  output logic [3:0]               rf_waddr,
  output logic [23:0]              rf_wdata,
  output logic [15:0]              pending,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [3:0]    ent_addr [DEPTH];
  logic [23:0]   ent_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [AW-1:0] scan_idx;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          take_alu;

  assign full       = (count == FULL_COUNT);
  assign empty      = (count == '0);
  assign mem_ready  = !full;
  assign alu_ready  = !full;
  assign fifo_count = count;

  // A full FIFO steals the port from the ALU so memory results cannot starve.
  assign push     = mem_valid && !full;
  assign pop      = full || (!alu_valid && !empty);
  assign take_alu = !full && alu_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage needs no reset: occupancy is defined purely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= mem_waddr;
      ent_data[wr_ptr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (pop) begin
      rf_we    <= 1'b1;
      rf_waddr <= ent_addr[rd_ptr];
      rf_wdata <= ent_data[rd_ptr];
    end else if (take_alu) begin
      rf_we    <= 1'b1;
      rf_waddr <= alu_waddr;
      rf_wdata <= alu_wdata;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Only the occupied window [rd_ptr, rd_ptr+count) contributes to the hazard mask.
  always_comb begin
    pending  = '0;
    scan_idx = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr + AW'(k);
      if (CW'(k) < count) begin
        pending[ent_addr[scan_idx]] = 1'b1;
      end
    end
    if (rf_we) begin
      pending[rf_waddr] = 1'b1;
    end
  end

endmodule

// File: tb/tb_regwb.sv
// tb/tb_regwb.sv - randomized and directed self-checking bench for regwb
module tb_regwb;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_waddr;
  logic [23:0] alu_wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_waddr;
  logic [23:0] mem_wdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [23:0] rf_wdata;
  logic [15:0] pending;
  logic [$clog2(DEPTH):0] fifo_count;

  always #5 clk = ~clk;

  regwb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending(pending), .fifo_count(fifo_count)
  );

  typedef struct packed {
    logic [3:0]  a;
    logic [23:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [3:0]  m_addr;
  logic [23:0] m_data;
  bit          acc_alu;
  bit          acc_mem;
  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_pending();
    logic [15:0] p;
    p = '0;
    foreach (q[i]) p[q[i].a] = 1'b1;
    if (m_we) p[m_addr] = 1'b1;
    return p;
  endfunction

  task automatic model_clear();
    q.delete();
    m_we = 1'b0;
    m_addr = '0;
    m_data = '0;
    acc_alu = 1'b1;
    acc_mem = 1'b1;
  endtask

  // One write-port decision per clock: full FIFO first, then ALU, then any buffered result.
  task automatic model_step();
    ent_t e;
    bit   full;
    full = (q.size() == DEPTH);
    acc_alu = alu_valid && !full;
    acc_mem = mem_valid && !full;
    if (full || (!alu_valid && q.size() != 0)) begin
      e = q.pop_front();
      m_we = 1'b1;
      m_addr = e.a;
      m_data = e.d;
    end else if (alu_valid) begin
      m_we = 1'b1;
      m_addr = alu_waddr;
      m_data = alu_wdata;
    end else begin
      m_we = 1'b0;
    end
    if (acc_mem) begin
      e.a = mem_waddr;
      e.d = mem_wdata;
      q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rf_we", 32'(rf_we), 32'(m_we));
      chk("rf_waddr", 32'(rf_waddr), 32'(m_addr));
      chk("rf_wdata", 32'(rf_wdata), 32'(m_data));
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("mem_ready", 32'(mem_ready), 32'(q.size() != DEPTH));
      chk("alu_ready", 32'(alu_ready), 32'(q.size() != DEPTH));
      chk("pending", 32'(pending), 32'(exp_pending()));
    end
  end

  task automatic cyc(input logic av, input logic [3:0] aa, input logic [23:0] ad,
                     input logic mv, input logic [3:0] ma, input logic [23:0] md);
    alu_valid = av;
    alu_waddr = aa;
    alu_wdata = ad;
    mem_valid = mv;
    mem_waddr = ma;
    mem_wdata = md;
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 24'd0, 1'b0, 4'd0, 24'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
    mem_valid = 1'b0; mem_waddr = '0; mem_wdata = '0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk_en = 1'b1;
    rst = 1'b0;
    chk("reset_rf_we", 32'(rf_we), 0);
    chk("reset_count", 32'(fifo_count), 0);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_mem_ready", 32'(mem_ready), 1);
    chk("reset_alu_ready", 32'(alu_ready), 1);

    // ALU single write
    cyc(1'b1, 4'd3, 24'h123456, 1'b0, 4'd0, 24'd0);
    chk("alu_we", 32'(rf_we), 1);
    chk("alu_waddr", 32'(rf_waddr), 3);
    chk("alu_wdata", 32'(rf_wdata), 32'h123456);
    chk("alu_pending", 32'(pending), 32'h0008);
    idle();
    chk("alu_we_drop", 32'(rf_we), 0);
    chk("alu_pending_drop", 32'(pending), 0);
    chk("alu_waddr_hold", 32'(rf_waddr), 3);

    // Memory latency
    cyc(1'b0, 4'd0, 24'd0, 1'b1, 4'd7, 24'hABCDEF);
    chk("mem_lat_we0", 32'(rf_we), 0);
    chk("mem_lat_count", 32'(fifo_count), 1);
    chk("mem_lat_pending", 32'(pending), 32'h0080);
    idle();
    chk("mem_lat_we", 32'(rf_we), 1);
    chk("mem_lat_waddr", 32'(rf_waddr), 7);
    chk("mem_lat_wdata", 32'(rf_wdata), 32'hABCDEF);
    chk("mem_lat_count0", 32'(fifo_count), 0);
    idle();
    chk("mem_lat_we_drop", 32'(rf_we), 0);

    // Starvation guard
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 4'd2, 24'h000100 + 24'(i), 1'b1, 4'(10 + i), 24'hA00000 + 24'(i));
    chk("starve_count", 32'(fifo_count), 4);
    chk("starve_mem_ready", 32'(mem_ready), 0);
    chk("starve_alu_ready", 32'(alu_ready), 0);
    chk("starve_last_alu", 32'(rf_wdata), 32'h000103);
    cyc(1'b1, 4'd2, 24'h000104, 1'b0, 4'd0, 24'd0);
    chk("starve_pop_addr", 32'(rf_waddr), 10);
    chk("starve_pop_data", 32'(rf_wdata), 32'hA00000);
    chk("starve_alu_back", 32'(alu_ready), 1);
    cyc(1'b1, 4'd2, 24'h000104, 1'b0, 4'd0, 24'd0);
    chk("starve_alu_resume", 32'(rf_wdata), 32'h000104);
    chk("starve_count3", 32'(fifo_count), 3);
    for (int i = 1; i < 4; i++) begin
      idle();
      chk("starve_drain_addr", 32'(rf_waddr), 32'(10 + i));
      chk("starve_drain_data", 32'(rf_wdata), 32'hA00000 + 32'(i));
    end
    idle();
    chk("starve_done", 32'(rf_we), 0);

    // Simultaneous ALU and memory, then push+pop at count 2
    cyc(1'b1, 4'd4, 24'h444444, 1'b1, 4'd6, 24'h666666);
    chk("sim_alu_first", 32'(rf_waddr), 4);
    idle();
    chk("sim_mem_next", 32'(rf_wdata), 32'h666666);
    idle();
    cyc(1'b1, 4'd1, 24'h000111, 1'b1, 4'd8, 24'h800001);
    cyc(1'b1, 4'd1, 24'h000112, 1'b1, 4'd9, 24'h800002);
    chk("pp_count2", 32'(fifo_count), 2);
    cyc(1'b0, 4'd0, 24'd0, 1'b1, 4'd10, 24'h800003);
    chk("pp_count_stays", 32'(fifo_count), 2);
    chk("pp_head", 32'(rf_waddr), 8);
    repeat (3) idle();

    // Pending with duplicate destinations, then a long stream to wrap the pointers
    cyc(1'b1, 4'd0, 24'd1, 1'b1, 4'd5, 24'h500001);
    cyc(1'b1, 4'd0, 24'd2, 1'b1, 4'd5, 24'h500002);
    cyc(1'b1, 4'd0, 24'd3, 1'b1, 4'd9, 24'h900003);
    chk("dup_pending", 32'(pending), 32'h0221);
    idle();
    chk("dup_first", 32'(rf_wdata), 32'h500001);
    chk("dup_p5_a", 32'(pending[5]), 1);
    idle();
    chk("dup_second", 32'(rf_wdata), 32'h500002);
    chk("dup_p5_b", 32'(pending[5]), 1);
    idle();
    chk("dup_p5_clear", 32'(pending[5]), 0);
    chk("dup_p9", 32'(pending[9]), 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 4'd0, 24'd0, 1'b1, 4'(i), 24'hC00000 + 24'(i));
      if (i > 0) chk("wrap_order", 32'(rf_wdata), 32'hC00000 + 32'(i - 1));
    end
    idle();
    chk("wrap_last", 32'(rf_wdata), 32'hC00009);
    idle();

    // Reset mid-drain
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 4'd0, 24'd0, 1'b1, 4'(1 + i), 24'hD00000 + 24'(i));
    idle();
    do_reset();
    chk("rst_mid_we", 32'(rf_we), 0);
    chk("rst_mid_count", 32'(fifo_count), 0);
    chk("rst_mid_pending", 32'(pending), 0);
    chk("rst_mid_mem_ready", 32'(mem_ready), 1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("rst_mid_quiet", 32'(rf_we), 0);
    end

    // Randomized traffic honouring the hold-while-stalled rule
    for (int n = 0; n < 2000; n++) begin
      logic        av, mv;
      logic [3:0]  aa, ma;
      logic [23:0] ad, md;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        continue;
      end
      av = alu_valid; aa = alu_waddr; ad = alu_wdata;
      mv = mem_valid; ma = mem_waddr; md = mem_wdata;
      if (!alu_valid || acc_alu) begin
        av = ($urandom_range(0, 99) < 50);
        aa = 4'($urandom);
        ad = 24'($urandom);
      end
      if (!mem_valid || acc_mem) begin
        mv = ($urandom_range(0, 99) < 70);
        ma = 4'($urandom);
        md = 24'($urandom);
      end
      cyc(av, aa, ad, mv, ma, md);
    end
    repeat (6) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
